mem_serial_sequencer: RTL and testbench
=======================================

// Module: mem_serial_sequencer
// PURPOSE
//  Front-end command sequencer for the on-chip memory array under test. Accepts
//  serial command frames in SERIAL_BITS-wide chunks and assembles address/data.
//  Drives the array's write strobe with guard cycles around it, which latch-based
//  storage elements need. Returns read data through the same chunked protocol.
//  Sits between the top-level pin mux (ui_in/uo_out) and the memory array.
// PARAMETERS
//  ADDR_BITS        4  array address width
//  DATA_BITS        8  array word width
//  SERIAL_BITS      4  chunk width of the serial in/out channel
//  PRE_POST_DELAY   1  cycles addr/wdata held stable before and after mem_we (0..3)
//  READ_LATENCY     1  cycles from mem_addr valid to mem_rdata sampled (1..3)
// PORTS
//  clk        in   1            clock
//  reset      in   1            async reset, active-high
//  in_data    in   SERIAL_BITS  command chunk
//  in_valid   in   1            in_data valid
//  in_ready   out  1            chunk accepted when in_valid & in_ready
//  out_data   out  SERIAL_BITS  read-data chunk
//  out_valid  out  1            out_data valid
//  out_ready  in   1            chunk consumed when out_valid & out_ready
//  mem_addr   out  ADDR_BITS    array address
//  mem_wdata  out  DATA_BITS    array write data
//  mem_we     out  1            array write strobe, exactly 1 cycle per write
//  mem_rdata  in   DATA_BITS    array read data (combinational from mem_addr)
//  busy       out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; in_ready=1, out_valid=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, out_data=0, busy=0. Reset mid-write aborts, with no
//   mem_we pulse.
//  NA=ceil(ADDR_BITS/SERIAL_BITS), ND=ceil(DATA_BITS/SERIAL_BITS). All fields are
//   LSB chunk first. Excess high bits in the last chunk are ignored on input and
//   driven 0 on output.
//  Frame: header chunk (bit0: 1=write, 0=read; other bits ignored), then NA addr
//   chunks, then ND data chunks (write only).
//  States:
//   IDLE  -> ADDR on header accept.
//   ADDR  -> WDATA (write) or RWAIT (read) after NA chunks. mem_addr is updated
//     only at the final addr chunk.
//   WDATA -> PRE after ND chunks. mem_wdata is updated only at the final chunk.
//   PRE   holds PRE_POST_DELAY cycles (skipped if 0) -> WRITE.
//   WRITE 1 cycle with mem_we=1 -> POST.
//   POST  holds PRE_POST_DELAY cycles (skipped if 0) -> IDLE.
//   RWAIT holds READ_LATENCY cycles, then latches mem_rdata into the shift reg
//     -> ROUT.
//   ROUT  presents ND chunks. out_valid stays high until the handshake; the next
//     chunk follows the cycle after. After the last chunk -> IDLE.
//  in_ready=1 only in IDLE/ADDR/WDATA. Chunks offered elsewhere are stalled, not
//   dropped.
//  mem_addr/mem_wdata never change from PRE entry through POST exit.
//  mem_we is registered (glitch-free) and never asserted outside WRITE.
//  out_valid=1 only in ROUT. out_valid must not drop without a handshake.
//  Back-to-back frames: a header may be accepted in the cycle after the
//   POST/ROUT exit.
//  Write latency (default params): last data chunk accepted at cycle t ->
//   mem_we high at t+2 -> in_ready high at t+4.
// TESTING
//  Write A=5 D=0xA3: chunks 1,5,3,A -> exactly one mem_we with addr=5,
//   wdata=0xA3. addr/wdata are stable for 1 cycle before and 1 cycle after
//   mem_we.
//  Read A=5 after the write (array model): chunks 0,5 -> out chunks 3 then A.
//   No mem_we during the read.
//  out_ready held low 5 cycles during ROUT -> out_data stays 3 and out_valid
//   stays 1. No chunk is lost or duplicated.
//  in_valid held high continuously with a second write queued -> in_ready=0 in
//   PRE/WRITE/POST. The second frame is accepted intact right after POST.
//  Assert reset in the WDATA state (after chunk 3) -> outputs go to reset values
//   at once, with no mem_we. A fresh write to A=2 D=0x5C then succeeds.
//  Sweep all 16 addresses with write then read-back of ~addr pattern, with
//   PRE_POST_DELAY in {0,1,2} -> all reads match.

Source files
------------

// File: rtl/mem_serial_sequencer.sv
// Serial command sequencer in front of the memory array under test.
// Frames arrive as SERIAL_BITS-wide chunks, LSB chunk first:
//   header (bit0 = write), NA address chunks, ND data chunks (writes only).
// Writes are framed by PRE/POST guard cycles so latch-based storage sees a
// stable address and data around the single-cycle write strobe.
// Reads wait READ_LATENCY cycles, capture mem_rdata and stream it back
// over a valid/ready chunk channel.
module mem_serial_sequencer #(
   parameter int ADDR_BITS      = 4,
   parameter int DATA_BITS      = 8,
   parameter int SERIAL_BITS    = 4,
   parameter int PRE_POST_DELAY = 1,
   parameter int READ_LATENCY   = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SERIAL_BITS-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [SERIAL_BITS-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_BITS-1:0]   mem_addr,
   output logic [DATA_BITS-1:0]   mem_wdata,
   output logic                   mem_we,
   input  logic [DATA_BITS-1:0]   mem_rdata,
   output logic                   busy
);

   localparam int NA   = (ADDR_BITS + SERIAL_BITS - 1) / SERIAL_BITS;
   localparam int ND   = (DATA_BITS + SERIAL_BITS - 1) / SERIAL_BITS;
   localparam int NMAX = (NA > ND) ? NA : ND;
   // One shift register serves address assembly, data assembly and readout.
   localparam int SW   = NMAX * SERIAL_BITS;
   localparam int CMAX0 = (NMAX > PRE_POST_DELAY) ? NMAX : PRE_POST_DELAY;
   localparam int CMAX  = (CMAX0 > READ_LATENCY) ? CMAX0 : READ_LATENCY;
   localparam int CW    = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_PRE, S_WRITE, S_POST, S_RWAIT, S_ROUT
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         ser_q, ser_d;
   logic                  is_write_q, is_write_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [DATA_BITS-1:0]  wdata_q, wdata_d;
   logic                  in_ready_q, out_valid_q, mem_we_q, busy_q;

   logic                  in_acc;
   logic                  out_acc;
   logic [SW-1:0]         ser_in;

   assign in_acc  = in_valid & in_ready_q;
   assign out_acc = out_valid_q & out_ready;
   // New chunk enters at the top; after k chunks the field sits in the top k chunks.
   assign ser_in  = (ser_q >> SERIAL_BITS) | (SW'(in_data) << (SW - SERIAL_BITS));

   // Next-state, counter and datapath decisions for the frame sequencer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      state_d    = state_q;
      cnt_d      = cnt_q;
      ser_d      = ser_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_acc) begin
               is_write_d = in_data[0];
               cnt_d      = '0;
               ser_d      = '0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (in_acc) begin
               if (int'(cnt_q) == NA - 1) begin
                  addr_d  = ADDR_BITS'(ser_in >> (SW - NA * SERIAL_BITS));
                  cnt_d   = '0;
                  ser_d   = '0;
                  state_d = is_write_q ? S_WDATA : S_RWAIT;
               end else begin
                  ser_d = ser_in;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_WDATA: begin
            if (in_acc) begin
               if (int'(cnt_q) == ND - 1) begin
                  wdata_d = DATA_BITS'(ser_in >> (SW - ND * SERIAL_BITS));
                  cnt_d   = '0;
                  ser_d   = '0;
                  state_d = (PRE_POST_DELAY == 0) ? S_WRITE : S_PRE;
               end else begin
                  ser_d = ser_in;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_PRE: begin
            if (int'(cnt_q) == PRE_POST_DELAY - 1) begin
               cnt_d   = '0;
               state_d = S_WRITE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WRITE: begin
            state_d = (PRE_POST_DELAY == 0) ? S_IDLE : S_POST;
         end
         S_POST: begin
            if (int'(cnt_q) == PRE_POST_DELAY - 1) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RWAIT: begin
            if (int'(cnt_q) == READ_LATENCY - 1) begin
               ser_d   = SW'(mem_rdata);
               cnt_d   = '0;
               state_d = S_ROUT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_ROUT: begin
            if (out_acc) begin
               // Zero fill from the top drives excess bits of the last chunk low.
               ser_d = ser_q >> SERIAL_BITS;
               if (int'(cnt_q) == ND - 1) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs; outputs decode the next state so they change with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ser_q       <= '0;
         is_write_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values together.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ser_q       <= ser_d;
         is_write_q  <= is_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         in_ready_q  <= (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
         out_valid_q <= (state_d == S_ROUT);
         mem_we_q    <= (state_d == S_WRITE);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = ser_q[SERIAL_BITS-1:0];
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = mem_we_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_serial_sequencer.sv
// Directed bench for mem_serial_sequencer. Three instances differ only in
// PRE_POST_DELAY (0, 1, 2); each has its own behavioural array. Instance 1
// (default parameters) carries the directed scenarios; all three run the sweep.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_serial_sequencer;

   logic       clk;
   logic       reset;
   logic [3:0] in_data   [3];
   logic       in_valid  [3];
   logic       in_ready  [3];
   logic [3:0] out_data  [3];
   logic       out_valid [3];
   logic       out_ready [3];
   logic [3:0] mem_addr  [3];
   logic [7:0] mem_wdata [3];
   logic       mem_we    [3];
   logic [7:0] mem_rdata [3];
   logic       busy      [3];
   int         we_cnt_a  [3];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [7:0] mem [16];
      int         we_cnt = 0;

      mem_serial_sequencer #(
         .ADDR_BITS      (4),
         .DATA_BITS      (8),
         .SERIAL_BITS    (4),
         .PRE_POST_DELAY (g),
         .READ_LATENCY   (1)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_data   (in_data[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .out_data  (out_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_we    (mem_we[g]),
         .mem_rdata (mem_rdata[g]),
         .busy      (busy[g])
      );

      // Behavioural array: synchronous write, combinational read.
      always @(posedge clk) begin
         if (mem_we[g]) begin
            mem[mem_addr[g]] <= mem_wdata[g];
            we_cnt           <= we_cnt + 1;
         end
      end

      assign mem_rdata[g] = mem[mem_addr[g]];
      assign we_cnt_a[g]  = we_cnt;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one chunk (entered at a falling edge) and wait for its handshake.
   task automatic send_chunk(input int sel, input logic [3:0] d);
      bit ok = 1'b0;
      in_data[sel]  = d;
      in_valid[sel] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready[sel]) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check($sformatf("chunk_accept_timeout_i%0d", sel), 32'd0, 32'd1);
      @(negedge clk);
      in_valid[sel] = 1'b0;
   endtask

   // Write frame, then walk PRE/WRITE/POST checking strobe, hold and stall.
   // With queue_next the next header stays offered through the guard cycles.
   task automatic write_frame(input int sel, input logic [3:0] a, input logic [7:0] d,
                              input bit queue_next);
      int w0 = we_cnt_a[sel];
      string t = $sformatf("i%0d_a%0h", sel, a);
      send_chunk(sel, 4'h1);
      send_chunk(sel, a);
      send_chunk(sel, d[3:0]);
      send_chunk(sel, d[7:4]);
      if (queue_next) begin
         in_data[sel]  = 4'h1;
         in_valid[sel] = 1'b1;
      end
      for (int i = 0; i < sel; i++) begin
         check({"pre_we_", t},    32'(mem_we[sel]),    32'd0);
         check({"pre_rdy_", t},   32'(in_ready[sel]),  32'd0);
         check({"pre_addr_", t},  32'(mem_addr[sel]),  32'(a));
         check({"pre_wdata_", t}, 32'(mem_wdata[sel]), 32'(d));
         @(negedge clk);
      end
      check({"we_", t},       32'(mem_we[sel]),    32'd1);
      check({"we_rdy_", t},   32'(in_ready[sel]),  32'd0);
      check({"we_addr_", t},  32'(mem_addr[sel]),  32'(a));
      check({"we_wdata_", t}, 32'(mem_wdata[sel]), 32'(d));
      @(negedge clk);
      for (int i = 0; i < sel; i++) begin
         check({"post_we_", t},    32'(mem_we[sel]),    32'd0);
         check({"post_rdy_", t},   32'(in_ready[sel]),  32'd0);
         check({"post_addr_", t},  32'(mem_addr[sel]),  32'(a));
         check({"post_wdata_", t}, 32'(mem_wdata[sel]), 32'(d));
         @(negedge clk);
      end
      check({"idle_rdy_", t},  32'(in_ready[sel]), 32'd1);
      check({"idle_busy_", t}, 32'(busy[sel]),     32'd0);
      check({"idle_we_", t},   32'(mem_we[sel]),   32'd0);
      check({"we_count_", t},  32'(we_cnt_a[sel]), 32'(w0 + 1));
   endtask

   // Read frame; optionally hold out_ready low for 'stall' cycles on the first chunk.
   task automatic read_frame(input int sel, input logic [3:0] a, input logic [7:0] d,
                             input int stall);
      int   w0 = we_cnt_a[sel];
      bit   seen = 1'b0;
      logic [7:0] sh;
      logic [3:0] exp;
      string t = $sformatf("i%0d_a%0h", sel, a);
      send_chunk(sel, 4'h0);
      send_chunk(sel, a);
      for (int i = 0; i < 10; i++) begin
         if (out_valid[sel]) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({"rd_valid_seen_", t}, 32'(seen), 32'd1);
      for (int k = 0; k < 2; k++) begin
         sh  = d >> (4 * k);
         exp = sh[3:0];
         if (k == 0) begin
            for (int s = 0; s < stall; s++) begin
               check({"stall_valid_", t}, 32'(out_valid[sel]), 32'd1);
               check({"stall_data_", t},  32'(out_data[sel]),  32'(exp));
               @(negedge clk);
            end
         end
         check($sformatf("rd_valid%0d_%s", k, t), 32'(out_valid[sel]), 32'd1);
         check($sformatf("rd_data%0d_%s", k, t),  32'(out_data[sel]),  32'(exp));
         out_ready[sel] = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready[sel] = 1'b0;
      end
      check({"rd_done_valid_", t}, 32'(out_valid[sel]), 32'd0);
      check({"rd_done_busy_", t},  32'(busy[sel]),      32'd0);
      check({"rd_done_rdy_", t},   32'(in_ready[sel]),  32'd1);
      check({"rd_no_we_", t},      32'(we_cnt_a[sel]),  32'(w0));
   endtask

   task automatic check_reset_values(input int sel, input string t);
      check({t, "_in_ready"},  32'(in_ready[sel]),  32'd1);
      check({t, "_out_valid"}, 32'(out_valid[sel]), 32'd0);
      check({t, "_mem_we"},    32'(mem_we[sel]),    32'd0);
      check({t, "_mem_addr"},  32'(mem_addr[sel]),  32'd0);
      check({t, "_mem_wdata"}, 32'(mem_wdata[sel]), 32'd0);
      check({t, "_out_data"},  32'(out_data[sel]),  32'd0);
      check({t, "_busy"},      32'(busy[sel]),      32'd0);
   endtask

   initial begin
      int w0;
      logic [7:0] pat;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data[i]   = 4'h0;
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      check_reset_values(1, "reset");
      reset = 1'b0;
      @(negedge clk);

      // Basic write of A=5 D=0xA3, read back, then read back with a stalled consumer.
      write_frame(1, 4'h5, 8'hA3, 1'b0);
      read_frame(1, 4'h5, 8'hA3, 0);
      read_frame(1, 4'h5, 8'hA3, 5);

      // Second write queued with in_valid held high through the guard cycles.
      write_frame(1, 4'h9, 8'h3C, 1'b1);
      write_frame(1, 4'hE, 8'h71, 1'b0);
      read_frame(1, 4'h9, 8'h3C, 0);
      read_frame(1, 4'hE, 8'h71, 0);

      // Reset while assembling write data: outputs clear at once, no strobe.
      send_chunk(1, 4'h1);
      send_chunk(1, 4'h5);
      send_chunk(1, 4'h3);
      check("wdata_state_busy", 32'(busy[1]), 32'd1);
      w0 = we_cnt_a[1];
      #2 reset = 1'b1;
      #1 check_reset_values(1, "midreset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("midreset_no_we", 32'(we_cnt_a[1]), 32'(w0));
      @(negedge clk);
      write_frame(1, 4'h2, 8'h5C, 1'b0);
      read_frame(1, 4'h2, 8'h5C, 0);
      read_frame(1, 4'h5, 8'hA3, 0);

      // Address sweep with ~addr pattern for every guard-cycle setting.
      for (int s = 0; s < 3; s++) begin
         for (int a = 0; a < 16; a++) begin
            pat = ~8'(a);
            write_frame(s, 4'(a), pat, 1'b0);
         end
         for (int a = 0; a < 16; a++) begin
            pat = ~8'(a);
            read_frame(s, 4'(a), pat, 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
